// File: rtl/markov_predictor.sv
// markov_predictor
//
// Learns, for each context of the last HIST (computer, user) move pairs, how
// often the user plays rock / scissor / paper next, and answers with the move
// that beats the most likely user move. One round is absorbed every three
// cycles: IDLE (accept) -> UPDATE (count) -> DECIDE (pick next move).
//
// Move encoding everywhere: 00 rock, 01 scissor, 10 paper (11 is illegal).
//
// Parameters
//   COUNT_W  width of each frequency counter (unsigned, saturating with decay)
//   HIST     rounds of history forming the context (1 or 2)
//
// Ports
//   clock         system clock
//   reset         synchronous active-high reset, clears all control state and
//                 restarts the table-clear sweep
//   round_valid   one-cycle pulse: user_move/com_move hold the round just played
//   user_move     user move of that round
//   com_move      computer move of that round
//   rand_in       free-running random bits for fallback and tie-breaks
//   ready         high when a round can be accepted
//   choice        computer move for the next round, held between decisions
//   choice_valid  one-cycle pulse when choice is refreshed
//   illegal       one-cycle pulse: an offered round carried 11 on a move
//   overrun       one-cycle pulse: round_valid arrived while ready was low
module markov_predictor #(
    parameter int COUNT_W = 8,
    parameter int HIST    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       round_valid,
    input  logic [1:0] user_move,
    input  logic [1:0] com_move,
    input  logic [1:0] rand_in,
    output logic       ready,
    output logic [1:0] choice,
    output logic       choice_valid,
    output logic       illegal,
    output logic       overrun
);

    localparam int CTX_W = 4 * HIST;
    localparam int ROWS  = 1 << CTX_W;

    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [1:0]         HIST_FULL = 2'(HIST);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPDATE = 2'd2,
        DECIDE = 2'd3
    } state_t;

    state_t             state;
    logic [CTX_W-1:0]   ctx;
    logic [CTX_W-1:0]   init_row;
    logic [1:0]         hist_cnt;
    logic [1:0]         user_q;
    logic [1:0]         com_q;

    // Frequency table: one row per context, one counter per user move.
    logic [COUNT_W-1:0] tbl [ROWS][3];

    logic [COUNT_W-1:0] cur_cnt [3];
    logic [COUNT_W-1:0] upd_cnt [3];
    logic [COUNT_W-1:0] target_cnt;
    logic               decay;
    logic               hist_full;
    logic               clr_en;
    logic               upd_en;
    logic [CTX_W-1:0]   next_ctx;
    logic [1:0]         dec_choice;

    // Move that beats the predicted user move.
    function automatic logic [1:0] beat(input logic [1:0] pred);
        logic [1:0] m;
        case (pred)
            2'b00:   m = 2'b10;   // rock    -> paper
            2'b01:   m = 2'b00;   // scissor -> rock
            default: m = 2'b01;   // paper   -> scissor
        endcase
        return m;
    endfunction

    // Random fallback never produces the illegal code.
    function automatic logic [1:0] legal_rand(input logic [1:0] r);
        return (r == 2'b11) ? 2'b00 : r;
    endfunction

    // Index of the maximum counter. Callers rule out the all-equal case, so
    // any tie here is a two-way tie for the top; tb selects the higher index.
    function automatic logic [1:0] pick_max(input logic [COUNT_W-1:0] c0,
                                            input logic [COUNT_W-1:0] c1,
                                            input logic [COUNT_W-1:0] c2,
                                            input logic               tb);
        logic [1:0] p;
        if (c0 > c1 && c0 > c2)
            p = 2'd0;
        else if (c1 > c0 && c1 > c2)
            p = 2'd1;
        else if (c2 > c0 && c2 > c1)
            p = 2'd2;
        else if (c0 == c1 && c0 > c2)
            p = tb ? 2'd1 : 2'd0;
        else if (c0 == c2 && c0 > c1)
            p = tb ? 2'd2 : 2'd0;
        else
            p = tb ? 2'd2 : 2'd1;
        return p;
    endfunction

    // Counter update: halve the row when the target is pinned at its maximum,
    // then add one to the target, so the counter never wraps.
    function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] v,
                                                input logic               halve,
                                                input logic               hit);
        logic [COUNT_W-1:0] base;
        base = halve ? (v >> 1) : v;
        return hit ? base + COUNT_W'(1) : base;
    endfunction

    assign hist_full = (hist_cnt == HIST_FULL);

    // Oldest pair falls off the top; the newest pair enters the low nibble.
    assign next_ctx = CTX_W'({ctx, com_q, user_q});

    always_comb begin
        for (int k = 0; k < 3; k++)
            cur_cnt[k] = tbl[ctx][k];

        case (user_q)
            2'b00:   target_cnt = cur_cnt[0];
            2'b01:   target_cnt = cur_cnt[1];
            default: target_cnt = cur_cnt[2];
        endcase
        decay = (target_cnt == CNT_MAX);

        for (int k = 0; k < 3; k++)
            upd_cnt[k] = bump(cur_cnt[k], decay, user_q == 2'(k));
    end

    // In DECIDE, ctx already names the new context, so cur_cnt is its row.
    always_comb begin
        if (!hist_full || (cur_cnt[0] == cur_cnt[1] && cur_cnt[1] == cur_cnt[2]))
            dec_choice = legal_rand(rand_in);
        else
            dec_choice = beat(pick_max(cur_cnt[0], cur_cnt[1], cur_cnt[2], rand_in[0]));
    end

    assign clr_en = !reset && (state == INIT);
    assign upd_en = !reset && (state == UPDATE) && hist_full;

    // Table storage carries no reset; the INIT sweep clears it row by row.
    always_ff @(posedge clock) begin
        if (clr_en) begin
            for (int k = 0; k < 3; k++)
                tbl[init_row][k] <= '0;
        end else if (upd_en) begin
            for (int k = 0; k < 3; k++)
                tbl[ctx][k] <= upd_cnt[k];
        end
    end

    // Latched round moves are data and are not reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && round_valid && user_move != 2'b11 && com_move != 2'b11) begin
            user_q <= user_move;
            com_q  <= com_move;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= INIT;
            init_row     <= '0;
            ctx          <= '0;
            hist_cnt     <= 2'd0;
            ready        <= 1'b0;
            choice       <= 2'b00;
            choice_valid <= 1'b0;
            illegal      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            choice_valid <= 1'b0;
            illegal      <= 1'b0;
            overrun      <= 1'b0;

            // Rounds offered while busy are dropped without touching state.
            if (round_valid && state != IDLE)
                overrun <= 1'b1;

            case (state)
                // ---- INIT: clear one row per cycle ----
                INIT: begin
                    if (&init_row) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        init_row <= init_row + CTX_W'(1);
                    end
                end

                // ---- IDLE: accept a round ----
                IDLE: begin
                    if (round_valid) begin
                        if (user_move == 2'b11 || com_move == 2'b11) begin
                            illegal <= 1'b1;
                        end else begin
                            state <= UPDATE;
                            ready <= 1'b0;
                        end
                    end
                end

                // ---- UPDATE: count the user move, advance the context ----
                UPDATE: begin
                    ctx <= next_ctx;
                    if (!hist_full)
                        hist_cnt <= hist_cnt + 2'd1;
                    state <= DECIDE;
                end

                // ---- DECIDE: register the next computer move ----
                default: begin
                    choice       <= dec_choice;
                    choice_valid <= 1'b1;
                    ready        <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_markov_predictor.sv
// Directed bench for markov_predictor. Three instances share the clock:
//   index 0: COUNT_W=8, HIST=1  (reset/init, learning, illegal, overrun)
//   index 1: COUNT_W=3, HIST=1  (saturation decay and tie-break)
//   index 2: COUNT_W=8, HIST=2  (history fill, reset mid-round, 256-row init)
module tb_markov_predictor;

    logic       clock = 1'b0;
    logic [2:0] rst;
    logic [2:0] rv;
    logic [1:0] um [3];
    logic [1:0] cm [3];
    logic [1:0] rn [3];
    logic [2:0] rdy;
    logic [2:0] cv;
    logic [2:0] ill;
    logic [2:0] ovr;
    logic [1:0] ch [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    markov_predictor #(.COUNT_W(8), .HIST(1)) u_d1 (
        .clock(clock), .reset(rst[0]), .round_valid(rv[0]),
        .user_move(um[0]), .com_move(cm[0]), .rand_in(rn[0]),
        .ready(rdy[0]), .choice(ch[0]), .choice_valid(cv[0]),
        .illegal(ill[0]), .overrun(ovr[0])
    );

    markov_predictor #(.COUNT_W(3), .HIST(1)) u_c3 (
        .clock(clock), .reset(rst[1]), .round_valid(rv[1]),
        .user_move(um[1]), .com_move(cm[1]), .rand_in(rn[1]),
        .ready(rdy[1]), .choice(ch[1]), .choice_valid(cv[1]),
        .illegal(ill[1]), .overrun(ovr[1])
    );

    markov_predictor #(.COUNT_W(8), .HIST(2)) u_h2 (
        .clock(clock), .reset(rst[2]), .round_valid(rv[2]),
        .user_move(um[2]), .com_move(cm[2]), .rand_in(rn[2]),
        .ready(rdy[2]), .choice(ch[2]), .choice_valid(cv[2]),
        .illegal(ill[2]), .overrun(ovr[2])
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one legal round to instance i and check the 3-cycle handshake.
    task automatic play(input int i, input logic [1:0] u, input logic [1:0] c,
                        input logic [1:0] r, input logic [1:0] exp, input string tag);
        rv[i] = 1'b1;
        um[i] = u;
        cm[i] = c;
        rn[i] = r;
        tick();
        rv[i] = 1'b0;
        chk($sformatf("%s/rdy_t1", tag), rdy[i], 2'd0);
        tick();
        chk($sformatf("%s/rdy_t2", tag), rdy[i], 2'd0);
        chk($sformatf("%s/cv_t2", tag), cv[i], 2'd0);
        tick();
        chk($sformatf("%s/cv_t3", tag), cv[i], 2'd1);
        chk($sformatf("%s/choice", tag), ch[i], exp);
        chk($sformatf("%s/rdy_t3", tag), rdy[i], 2'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        bit  early;

        rst = '1;
        rv  = '0;
        for (int i = 0; i < 3; i++) begin
            um[i] = 2'b00;
            cm[i] = 2'b00;
            rn[i] = 2'b00;
        end
        tick();
        tick();

        // Reset values
        chk("rst/ready",  rdy[0], 2'd0);
        chk("rst/choice", ch[0],  2'b00);
        chk("rst/cv",     cv[0],  2'd0);
        chk("rst/ill",    ill[0], 2'd0);
        chk("rst/ovr",    ovr[0], 2'd0);

        // INIT sweep: ready rises on the 16th cycle after reset release
        rst = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("init/rdy_%0d", k), rdy[0], (k == 16) ? 2'd1 : 2'd0);
            chk($sformatf("init/cv_%0d", k), cv[0], 2'd0);
        end
        chk("init/choice", ch[0], 2'b00);
        chk("init/c3_rdy", rdy[1], 2'd1);
        chk("init/h2_rdy", rdy[2], 2'd0);

        // First round: empty history -> random 01
        play(0, 2'b00, 2'b00, 2'b01, 2'b01, "first_rand");
        tick();
        chk("first_rand/cv_drop", cv[0], 2'd0);

        // Row 0 learns rock: 1, 2, 3 -> answer paper
        play(0, 2'b00, 2'b00, 2'b01, 2'b10, "rock1");
        play(0, 2'b00, 2'b00, 2'b01, 2'b10, "rock2");
        play(0, 2'b00, 2'b00, 2'b01, 2'b10, "rock3");

        // Illegal user move
        rv[0] = 1'b1; um[0] = 2'b11; cm[0] = 2'b00;
        tick();
        rv[0] = 1'b0;
        chk("ill_u/pulse", ill[0], 2'd1);
        chk("ill_u/rdy",   rdy[0], 2'd1);
        chk("ill_u/cv",    cv[0],  2'd0);
        tick();
        chk("ill_u/drop",  ill[0], 2'd0);
        chk("ill_u/cv2",   cv[0],  2'd0);

        // Illegal computer move
        rv[0] = 1'b1; um[0] = 2'b00; cm[0] = 2'b11;
        tick();
        rv[0] = 1'b0;
        chk("ill_c/pulse", ill[0], 2'd1);
        chk("ill_c/rdy",   rdy[0], 2'd1);
        tick();
        chk("ill_c/cv",    cv[0],  2'd0);

        // Overrun: second round_valid one cycle after a legal accept
        rv[0] = 1'b1; um[0] = 2'b00; cm[0] = 2'b00; rn[0] = 2'b01;
        tick();
        um[0] = 2'b01;
        chk("ovr/none_t1", ovr[0], 2'd0);
        tick();
        rv[0] = 1'b0;
        chk("ovr/pulse", ovr[0], 2'd1);
        chk("ovr/rdy",   rdy[0], 2'd0);
        tick();
        chk("ovr/cv",     cv[0],  2'd1);
        chk("ovr/choice", ch[0],  2'b10);
        chk("ovr/drop",   ovr[0], 2'd0);

        // Unseen context with random 11 -> fallback maps to rock
        play(0, 2'b01, 2'b00, 2'b11, 2'b00, "rand11");
        // Back to row 0: rock 4 vs scissor 1 -> paper
        play(0, 2'b00, 2'b00, 2'b01, 2'b10, "row0_back");

        // COUNT_W=3: build row 0 to scissor 4, rock 7
        play(1, 2'b00, 2'b00, 2'b01, 2'b01, "c3_fill");
        for (int k = 1; k <= 4; k++) begin
            play(1, 2'b01, 2'b00, 2'b01, (k == 1) ? 2'b01 : 2'b10, $sformatf("c3_sc%0d", k));
            play(1, 2'b00, 2'b00, 2'b01, 2'b00, $sformatf("c3_row0_%0d", k));
        end
        for (int j = 1; j <= 7; j++)
            play(1, 2'b00, 2'b00, 2'b01, (j <= 4) ? 2'b00 : 2'b10, $sformatf("c3_rock%0d", j));
        // Rock saturated: row halves to 3/2/0, then rock -> 4
        play(1, 2'b00, 2'b00, 2'b01, 2'b10, "c3_decay");
        play(1, 2'b01, 2'b00, 2'b01, 2'b10, "c3_sc_b");
        play(1, 2'b00, 2'b00, 2'b01, 2'b10, "c3_r4s3");
        play(1, 2'b01, 2'b00, 2'b01, 2'b10, "c3_sc_c");
        // rock 4 = scissor 4, rand_in[0]=1 -> scissor predicted -> rock
        play(1, 2'b00, 2'b00, 2'b01, 2'b00, "c3_tie_hi");

        // HIST=2
        w = 0;
        while (!rdy[2] && w < 400) begin
            tick();
            w++;
        end
        chk("h2/ready_wait", rdy[2], 2'd1);
        play(2, 2'b00, 2'b00, 2'b10, 2'b10, "h2_fill1");
        play(2, 2'b01, 2'b10, 2'b01, 2'b01, "h2_fill2");

        // Reset during DECIDE of an accepted round
        rv[2] = 1'b1; um[2] = 2'b00; cm[2] = 2'b00; rn[2] = 2'b10;
        tick();
        rv[2] = 1'b0;
        tick();
        rst[2] = 1'b1;
        tick();
        chk("h2_rst/cv",     cv[2],  2'd0);
        chk("h2_rst/rdy",    rdy[2], 2'd0);
        chk("h2_rst/choice", ch[2],  2'b00);
        rst[2] = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k < 255 && rdy[2])
                early = 1'b1;
            if (k == 255)
                chk("h2_rst/rdy_255", rdy[2], 2'd0);
            if (k == 256)
                chk("h2_rst/rdy_256", rdy[2], 2'd1);
        end
        chk("h2_rst/no_early", {1'b0, early}, 2'd0);
        // History was cleared, so the fallback is random again
        play(2, 2'b00, 2'b00, 2'b10, 2'b10, "h2_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/markov_predictor.md
# markov_predictor

Parametrised successor to the order-1 Markov opponent. It learns, per history context of past (computer, user) move pairs, how often the user plays each move, then plays the move that beats the most likely next user move. The block sits between the round-scoring logic and the computer-choice mux. Over the earlier Markov opponent it adds:
- configurable history depth and counter width;
- saturating counters with row decay;
- a clean ready/valid handshake;
- an explicit table-clear sequence.

## Interface
- COUNT_W, default 8: width of each frequency counter.
- HIST, default 1: number of past rounds forming the context (1 or 2). Context width is 4*HIST bits; the table has 16^HIST rows of 3 counters.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; clears all state.
- round_valid  in  1  one-cycle pulse: the round just played is on user_move/com_move.
- user_move  in  2  user move of that round: 00 rock, 01 scissor, 10 paper.
- com_move  in  2  computer move of that round, same encoding.
- rand_in  in  2  free-running random source used for fallback and tie-breaks.
- ready  out  1  high when a round can be accepted.
- choice  out  2  computer move for the next round; holds until the next decision.
- choice_valid  out  1  one-cycle pulse when choice is updated.
- illegal  out  1  one-cycle pulse when an accepted round carried 11 on either move.
- overrun  out  1  one-cycle pulse when round_valid arrives while ready=0.

## Operation
- States: INIT, IDLE, UPDATE, DECIDE.
- **INIT**: clears one table row per cycle over rows 0..16^HIST-1, then enters IDLE. ready=0 throughout.
- **IDLE**: ready=1. On round_valid, latches both moves and goes to UPDATE.
  - If either move is 11: pulse illegal, do not latch, stay in IDLE.
- **UPDATE**: if the history is full (hist_cnt==HIST), counter[ctx][user_move] is incremented.
  - If that counter equals 2^COUNT_W-1, all three counters of the row are first shifted right by 1, then the target is incremented. The counter never wraps.
  - ctx shifts left by 4 and {com_move,user_move} is inserted in the low nibble.
  - hist_cnt increments, saturating at HIST.
- **DECIDE**: reads row ctx (the new context) and registers choice. Then returns to IDLE.
  - If hist_cnt<HIST, or all three counters are equal: choice = rand_in, with 11 mapped to 00.
  - Unique maximum: predicted move = its index.
  - Two-way tie for the maximum: predicted = lower index if rand_in[0]==0, else higher index.
  - Beat mapping: predicted rock→paper (10), scissor→rock (00), paper→scissor (01).
- Any round_valid outside IDLE pulses overrun and is dropped. State is unaffected.
- Reset values: ready=0, choice=00, choice_valid=0, illegal=0, overrun=0, ctx=0, hist_cnt=0, state=INIT. Reset has priority in every state, including mid-INIT and mid-UPDATE.

## Timing
- After reset deasserts (first cycle with reset=0, call it c0), INIT runs for 16^HIST cycles. ready rises at c0+16^HIST.
- round_valid accepted at cycle t: ready=0 during t+1 and t+2. choice updates and choice_valid pulses at t+3. ready=1 at t+3.
- A new round_valid may be accepted at t+3, giving a throughput of one round per 3 cycles.
- illegal and overrun are asserted the cycle after the offending round_valid.
- Counter arithmetic is unsigned COUNT_W bits. The comparator for the maximum is a pure compare within DECIDE with no extra latency.

## Test plan
- Reset then wait (HIST=1): ready stays 0 for 16 cycles after reset deasserts and rises on cycle 16. choice=00, and no pulses occur.
- HIST=1, rand_in=01, first round (user 00, com 00): hist_cnt=0 at decide → choice=01 (random), choice_valid at t+3.
- HIST=1: feed rounds user 00 / com 00 three times, then a fourth round user 00 / com 00. Row 0 then holds rock=3 → choice=10 (paper).
- COUNT_W=3: drive row 0 to rock=7 and scissor=4, then one more rock in the same context. Row becomes rock=4, scissor=2, paper=0, and choice=10.
- round_valid with user_move=11 → illegal pulse, ready remains 1, no choice_valid. round_valid at t+1 after a legal accept → overrun pulse, and the original choice still arrives at t+3.
- HIST=2: assert reset at t+2 of an accepted round → no choice_valid, INIT restarts, and ready rises 256 cycles after reset deasserts.
